// File: rtl/audvid_clock_enable_gen.sv
// rtl/audvid_clock_enable_gen.sv - multi-channel fractional clock-enable generator gated by MMCM lock
module audvid_clock_enable_gen #(
  parameter int               NUM_CH      = 3,
  parameter int               ACC_W       = 24,
  parameter int               SEQ_LEN     = 8,
  parameter logic [ACC_W-1:0] INC_DEFAULT = '0,
  localparam int              CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              MasterCLK,
  input  logic              ResetN,
  input  logic              LockIn,
  input  logic [NUM_CH-1:0] ChEnable,
  input  logic              CfgValid,
  output logic              CfgReady,
  input  logic [CH_W-1:0]   CfgCh,
  input  logic [ACC_W-1:0]  CfgInc,
  output logic [NUM_CH-1:0] TickOut,
  output logic [NUM_CH-1:0] PhaseOut,
  output logic              Running
);

  logic               sync1, sync2;
  logic [SEQ_LEN-1:0] lock_sr;
  logic [ACC_W-1:0]   acc [NUM_CH];
  logic [ACC_W-1:0]   inc [NUM_CH];
  logic [CH_W-1:0]    pend_ch;
  logic [ACC_W-1:0]   pend_inc;

  logic               active;
  logic [ACC_W:0]     sum [NUM_CH];
  logic [NUM_CH-1:0]  run_ch;
  logic [NUM_CH-1:0]  carry;
  logic               pend_in_range;
  logic               pend_hit;
  logic               pend_done;

  assign Running = lock_sr[SEQ_LEN-1];
  // sync2 also gates so the accumulators clear on the same edge Running drops
  assign active  = Running & sync2;

  always_comb begin
    pend_in_range = 1'b0;
    pend_hit      = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      run_ch[i]   = active & ChEnable[i];
      sum[i]      = {1'b0, acc[i]} + {1'b0, inc[i]};
      carry[i]    = run_ch[i] & sum[i][ACC_W];
      PhaseOut[i] = acc[i][ACC_W-1];
      if (pend_ch == CH_W'(i)) begin
        pend_in_range = 1'b1;
        pend_hit      = carry[i] | ~run_ch[i];
      end
    end
    // An out-of-range channel retires the pending slot without touching any Inc
    pend_done = ~CfgReady & (pend_hit | ~pend_in_range);
  end

  always_ff @(posedge MasterCLK or negedge ResetN) begin
    if (!ResetN) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      lock_sr  <= '0;
      pend_ch  <= '0;
      pend_inc <= '0;
      CfgReady <= 1'b1;
      TickOut  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        inc[i] <= INC_DEFAULT;
      end
    end else begin
      sync1   <= LockIn;
      sync2   <= sync1;
      lock_sr <= sync2 ? SEQ_LEN'({lock_sr, 1'b1}) : '0;
      TickOut <= carry;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= run_ch[i] ? sum[i][ACC_W-1:0] : '0;
        // The overflowing add still used the old increment; the new one starts next add
        if (pend_done && pend_in_range && pend_ch == CH_W'(i))
          inc[i] <= pend_inc;
      end
      if (CfgReady) begin
        if (CfgValid) begin
          pend_ch  <= CfgCh;
          pend_inc <= CfgInc;
          CfgReady <= 1'b0;
        end
      end else if (pend_done) begin
        CfgReady <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audvid_clock_enable_gen.sv
// tb/tb_audvid_clock_enable_gen.sv - directed table-driven bench for audvid_clock_enable_gen
module tb_audvid_clock_enable_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lock_in;
  logic [2:0]  ch_enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [23:0] cfg_inc;
  logic [2:0]  tick_out;
  logic [2:0]  phase_out;
  logic        running;

  int checks   = 0;
  int failures = 0;

  audvid_clock_enable_gen #(
    .NUM_CH(3), .ACC_W(24), .SEQ_LEN(8), .INC_DEFAULT(24'h0)
  ) dut (
    .MasterCLK(clk),
    .ResetN(rst_n),
    .LockIn(lock_in),
    .ChEnable(ch_enable),
    .CfgValid(cfg_valid),
    .CfgReady(cfg_ready),
    .CfgCh(cfg_ch),
    .CfgInc(cfg_inc),
    .TickOut(tick_out),
    .PhaseOut(phase_out),
    .Running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic       tick0;
    logic       phase0;
    logic       ready;
    logic       tick1;
  } vec_t;

  vec_t vecs [17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write_idle(input logic [1:0] ch, input logic [23:0] val);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_inc   = val;
    step();
    cfg_valid = 1'b0;
    chk("cfg_accept_ready", cfg_ready, 0);
    step();
    chk("cfg_apply_ready", cfg_ready, 1);
  endtask

  task automatic qualify_lock();
    lock_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("lock_running_e%0d", k), running, (k >= 10) ? 1 : 0);
      chk($sformatf("lock_tick_e%0d", k), tick_out, 0);
    end
  endtask

  initial begin
    int cnt0, cnt1, cnt2, bad_gap, last1, first0, first1;

    // Rows cover edges 11..27 after lock; a retune to 2^21 is offered before edge 15
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_n     = 1'b0;
    lock_in   = 1'b0;
    ch_enable = 3'b000;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_inc   = 24'h0;
    repeat (3) step();
    chk("rst_running", running, 0);
    chk("rst_tick", tick_out, 0);
    chk("rst_phase", phase_out, 0);
    chk("rst_ready", cfg_ready, 1);

    rst_n = 1'b1;
    step();
    cfg_write_idle(2'd0, 24'h400000);
    cfg_write_idle(2'd1, 24'h555555);
    cfg_write_idle(2'd2, 24'h000000);
    cfg_write_idle(2'd3, 24'h123456);

    ch_enable = 3'b111;
    qualify_lock();

    for (int r = 0; r < 17; r++) begin
      cfg_valid = vecs[r].valid;
      cfg_ch    = 2'd0;
      cfg_inc   = 24'h200000;
      step();
      chk($sformatf("vec%0d_tick0", r), tick_out[0], vecs[r].tick0);
      chk($sformatf("vec%0d_phase0", r), phase_out[0], vecs[r].phase0);
      chk($sformatf("vec%0d_ready", r), cfg_ready, vecs[r].ready);
      chk($sformatf("vec%0d_tick1", r), tick_out[1], vecs[r].tick1);
      chk($sformatf("vec%0d_tick2", r), tick_out[2], 0);
    end
    cfg_valid = 1'b0;

    // Edges 28..3027: ch1 ticks on edges 29,32,..; ch0 (period 8) on 34,42,..
    cnt0 = 0; cnt1 = 0; cnt2 = 0; bad_gap = 0; last1 = -2;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (tick_out[0]) cnt0++;
      if (tick_out[2]) cnt2++;
      if (tick_out[1]) begin
        cnt1++;
        if (n - last1 != 3) bad_gap++;
        last1 = n;
      end
    end
    chk("frac_count_ch1", cnt1, 1000);
    chk("frac_gap_ch1", bad_gap, 0);
    chk("retuned_count_ch0", cnt0, 375);
    chk("zero_inc_ch2", cnt2, 0);

    lock_in = 1'b0;
    step();
    chk("drop_running_e1", running, 1);
    step();
    chk("drop_running_e2", running, 1);
    step();
    chk("drop_running_e3", running, 0);
    chk("drop_tick_e3", tick_out, 0);
    chk("drop_phase_e3", phase_out, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("idle_tick_%0d", k), tick_out, 0);
      chk($sformatf("idle_phase_%0d", k), phase_out, 0);
    end

    qualify_lock();
    first0 = 0; first1 = 0;
    for (int k = 11; k <= 18; k++) begin
      step();
      if (k == 11) chk("relock_phase_e11", phase_out, 0);
      if (tick_out[0] && first0 == 0) first0 = k;
      if (tick_out[1] && first1 == 0) first1 = k;
    end
    chk("relock_first_tick0", first0, 18);
    chk("relock_first_tick1", first1, 14);

    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_inc   = 24'h400000;
    step();
    cfg_valid = 1'b0;
    chk("pend_ready_accept", cfg_ready, 0);
    repeat (3) step();
    chk("pend_ready_hold", cfg_ready, 0);
    chk("pre_reset_phase0", phase_out[0], 1);
    chk("pre_reset_running", running, 1);

    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_running", running, 0);
    chk("async_rst_tick", tick_out, 0);
    chk("async_rst_phase", phase_out, 0);
    chk("async_rst_ready", cfg_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", cfg_ready, 1);
    chk("post_rst_running", running, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
